// File: rtl/eth_tx_frame_arb.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_frame_arb
//  Purpose  : Frame-atomic round-robin arbiter merging S_COUNT 8-bit
//             AXI4-Stream sources onto one output stream that feeds the FCS
//             inserter. Once a port is granted it owns the output until its
//             tlast beat is accepted. An optional idle gap of GAP_CYCLES
//             follows every frame before the next arbitration.
//
//  Parameters
//    S_COUNT     number of source ports (2..8)
//    GAP_CYCLES  idle cycles inserted after each frame (0..255)
//
//  Ports
//    clk, rst        clock / synchronous active-high reset
//    s_axis_*        source ports; port i data lives in tdata[8i+7:8i]
//    m_axis_*        merged output stream (zero-latency pass-through)
//    grant_valid     a port currently owns the output (ACTIVE)
//    grant_index     owning port; holds the last granted port otherwise
//    busy            registered, high while the arbiter is not IDLE
//
//  Revision : 1.0  initial release
// ============================================================================
module eth_tx_frame_arb #(
    parameter int S_COUNT    = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [8*S_COUNT-1:0]   s_axis_tdata,
    input  logic [S_COUNT-1:0]     s_axis_tvalid,
    output logic [S_COUNT-1:0]     s_axis_tready,
    input  logic [S_COUNT-1:0]     s_axis_tlast,
    input  logic [S_COUNT-1:0]     s_axis_tuser,

    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,

    output logic                   grant_valid,
    output logic [2:0]             grant_index,
    output logic                   busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_active = 2'd1;
    localparam logic [1:0] c_st_gap    = 2'd2;

    localparam logic [7:0] c_gap_load  = 8'(GAP_CYCLES);
    localparam logic [2:0] c_last_port = 3'(S_COUNT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [2:0] r_grant;
    logic [2:0] r_last_grant;
    logic [7:0] r_gap_cnt;
    logic       r_busy;

    logic [1:0] w_state_next;
    logic [2:0] w_grant_next;
    logic [2:0] w_last_grant_next;
    logic [7:0] w_gap_cnt_next;

    // ------------------------------------------------------------------------
    // Source vectors zero-padded to the full 8-port width so that the 3-bit
    // grant register can index them directly for any legal S_COUNT.
    // ------------------------------------------------------------------------
    logic [7:0]  w_valid_pad;
    logic [7:0]  w_last_pad;
    logic [7:0]  w_user_pad;
    logic [63:0] w_data_pad;
    logic [7:0]  w_ready_pad;

    always_comb begin
        w_valid_pad                  = '0;
        w_last_pad                   = '0;
        w_user_pad                   = '0;
        w_data_pad                   = '0;
        w_valid_pad[S_COUNT-1:0]     = s_axis_tvalid;
        w_last_pad[S_COUNT-1:0]      = s_axis_tlast;
        w_user_pad[S_COUNT-1:0]      = s_axis_tuser;
        w_data_pad[8*S_COUNT-1:0]    = s_axis_tdata;
    end

    // ------------------------------------------------------------------------
    // Round-robin search: examine ports last_grant+1, last_grant+2, ...
    // (mod S_COUNT) and take the first one presenting tvalid.
    // ------------------------------------------------------------------------
    logic       w_rr_found;
    logic [2:0] w_rr_winner;
    logic [3:0] w_rr_sum;

    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = r_last_grant;
        w_rr_sum    = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            w_rr_sum = {1'b0, r_last_grant} + 4'(k);
            if (w_rr_sum >= 4'(S_COUNT)) begin
                w_rr_sum = w_rr_sum - 4'(S_COUNT);
            end
            if (!w_rr_found && w_valid_pad[w_rr_sum[2:0]]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = w_rr_sum[2:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output path. rst gates the handshake so that nothing transfers in the
    // reset cycle even though the state register still shows ACTIVE.
    // ------------------------------------------------------------------------
    logic w_active;
    logic w_xfer;

    assign w_active      = (r_state == c_st_active) && !rst;
    assign m_axis_tvalid = w_active && w_valid_pad[r_grant];
    assign m_axis_tdata  = w_data_pad[{r_grant, 3'b000} +: 8];
    assign m_axis_tlast  = w_last_pad[r_grant];
    assign m_axis_tuser  = w_user_pad[r_grant];
    assign w_xfer        = m_axis_tvalid && m_axis_tready;

    always_comb begin
        w_ready_pad          = '0;
        w_ready_pad[r_grant] = w_active && m_axis_tready;
    end

    assign s_axis_tready = w_ready_pad[S_COUNT-1:0];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        w_gap_cnt_next    = r_gap_cnt;

        case (r_state)
            c_st_idle: begin
                if (w_rr_found) begin
                    w_state_next      = c_st_active;
                    w_grant_next      = w_rr_winner;
                    w_last_grant_next = w_rr_winner;
                end
            end

            c_st_active: begin
                // The frame ends only on an accepted tlast beat; a stalled
                // owner keeps the grant indefinitely.
                if (w_xfer && m_axis_tlast) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_next   = c_st_gap;
                        w_gap_cnt_next = c_gap_load;
                    end else begin
                        w_state_next   = c_st_idle;
                    end
                end
            end

            c_st_gap: begin
                // Counter enters at GAP_CYCLES and the state leaves as it
                // passes 1, giving exactly GAP_CYCLES cycles in GAP.
                w_gap_cnt_next = r_gap_cnt - 8'd1;
                if (r_gap_cnt <= 8'd1) begin
                    w_state_next   = c_st_idle;
                    w_gap_cnt_next = 8'd0;
                end
            end

            default: begin
                w_state_next   = c_st_idle;
                w_gap_cnt_next = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_grant      <= 3'd0;
            r_last_grant <= c_last_port;
            r_gap_cnt    <= 8'd0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_busy       <= (w_state_next != c_st_idle);
        end
    end

    assign grant_valid = (r_state == c_st_active);
    assign grant_index = r_grant;
    assign busy        = r_busy;

endmodule
`default_nettype wire
